// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester and memory-write-side bundle for fb_write_arbiter
// master: camera/host/clear requesters and memory write side (testbench or system top)
// slave : fb_write_arbiter
//   cam_valid, cam_sof, cam_data            camera pixel stream (cannot stall)
//   host_req, host_addr, host_data          host single-word write, held until host_ack
//   host_ack, host_err                      host completion pulses
//   clear_start, clear_busy                 clear engine control/status
//   frame_done                              pulse with the write of the last camera address
//   mem_we, mem_waddr, mem_wdata            registered frame-buffer write port
interface fb_write_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 12
);
   logic              cam_valid;
   logic              cam_sof;
   logic [DATA_W-1:0] cam_data;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_data;
   logic              host_ack;
   logic              host_err;
   logic              clear_start;
   logic              clear_busy;
   logic              frame_done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output cam_valid, cam_sof, cam_data,
      output host_req, host_addr, host_data,
      output clear_start,
      input  host_ack, host_err, clear_busy, frame_done,
      input  mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  cam_valid, cam_sof, cam_data,
      input  host_req, host_addr, host_data,
      input  clear_start,
      output host_ack, host_err, clear_busy, frame_done,
      output mem_we, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - fixed-priority frame-buffer write-port arbiter (camera > host > clear)
// clk  : single rising-edge clock
// rstn : asynchronous active-low reset; abandons any frame or clear in progress
// bus  : fb_write_arbiter_if.slave carrying the three requesters and the memory write side
// All outputs are registered: a grant at edge N shows on the write port after edge N.
module fb_write_arbiter #(
   parameter int                DEPTH       = 153600,
   parameter int                ADDR_W      = 19,
   parameter int                DATA_W      = 12,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
   input logic                 clk,
   input logic                 rstn,
   fb_write_arbiter_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   // One extra bit so the range test on host_addr cannot overflow.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic {IDLE, CLEAR} clearState_t;

   clearState_t       clearState;
   logic [ADDR_W-1:0] camAddr;
   logic [ADDR_W-1:0] clearCnt;
   logic [ADDR_W-1:0] camWrAddr;
   logic              camGrant;
   logic              hostGrant;
   logic              clearGrant;
   logic              hostInRange;

   logic              memWe;
   logic [ADDR_W-1:0] memWaddr;
   logic [DATA_W-1:0] memWdata;
   logic              hostAck;
   logic              hostErr;
   logic              frameDone;
   logic              clearBusy;

   always_comb begin
      camWrAddr   = bus.cam_sof ? '0 : camAddr;
      camGrant    = bus.cam_valid;
      hostGrant   = bus.host_req && !bus.cam_valid;
      // Clear only gets cycles nobody else wants; its counter simply waits otherwise.
      clearGrant  = (clearState == CLEAR) && !bus.cam_valid && !bus.host_req;
      hostInRange = {1'b0, bus.host_addr} < DEPTH_EXT;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clearState <= IDLE;
         camAddr    <= '0;
         clearCnt   <= '0;
         memWe      <= 1'b0;
         memWaddr   <= '0;
         memWdata   <= '0;
         hostAck    <= 1'b0;
         hostErr    <= 1'b0;
         frameDone  <= 1'b0;
         clearBusy  <= 1'b0;
      end else begin
         memWe     <= 1'b0;
         hostAck   <= 1'b0;
         hostErr   <= 1'b0;
         frameDone <= 1'b0;

         if (camGrant) begin
            memWe     <= 1'b1;
            memWaddr  <= camWrAddr;
            memWdata  <= bus.cam_data;
            frameDone <= (camWrAddr == LAST_ADDR);
            camAddr   <= (camWrAddr == LAST_ADDR) ? '0 : camWrAddr + ADDR_W'(1);
         end else begin
            if (bus.cam_sof) begin
               camAddr <= '0;
            end
            if (hostGrant) begin
               hostAck <= 1'b1;
               hostErr <= !hostInRange;
               // Out-of-range requests are consumed without touching memory;
               // address/data keep their previous values like any idle cycle.
               if (hostInRange) begin
                  memWe    <= 1'b1;
                  memWaddr <= bus.host_addr;
                  memWdata <= bus.host_data;
               end
            end else if (clearGrant) begin
               memWe    <= 1'b1;
               memWaddr <= clearCnt;
               memWdata <= CLEAR_COLOR;
            end
         end

         case (clearState)
            IDLE: begin
               if (bus.clear_start) begin
                  clearState <= CLEAR;
                  clearCnt   <= '0;
                  clearBusy  <= 1'b1;
               end
            end
            CLEAR: begin
               // clear_start is ignored here: a running clear is never restarted.
               if (clearGrant) begin
                  if (clearCnt == LAST_ADDR) begin
                     clearState <= IDLE;
                     clearBusy  <= 1'b0;
                  end else begin
                     clearCnt <= clearCnt + ADDR_W'(1);
                  end
               end
            end
            default: begin
               clearState <= IDLE;
               clearBusy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_we     = memWe;
   assign bus.mem_waddr  = memWaddr;
   assign bus.mem_wdata  = memWdata;
   assign bus.host_ack   = hostAck;
   assign bus.host_err   = hostErr;
   assign bus.frame_done = frameDone;
   assign bus.clear_busy = clearBusy;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - directed scoreboard bench for fb_write_arbiter with DEPTH=16
module tb_fb_write_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 12;
   localparam int DEPTH  = 16;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              ack;
      logic              err;
      logic              fd;
      logic              busy;
   } exp_t;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   exp_t sb[$];
   logic [ADDR_W-1:0] heldAddr;
   logic [DATA_W-1:0] heldData;

   fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fb_write_arbiter #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected outputs after the next rising edge; address/data hold when no write.
   task automatic push(input logic we, input int addr, input int data,
                       input logic ack, input logic err, input logic fd, input logic busy);
      exp_t e;
      if (we) begin
         heldAddr = ADDR_W'(addr);
         heldData = DATA_W'(data);
      end
      e.we = we; e.addr = heldAddr; e.data = heldData;
      e.ack = ack; e.err = err; e.fd = fd; e.busy = busy;
      sb.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("mem_we",     32'(bus.mem_we),     32'(e.we));
         chk("mem_waddr",  32'(bus.mem_waddr),  32'(e.addr));
         chk("mem_wdata",  32'(bus.mem_wdata),  32'(e.data));
         chk("host_ack",   32'(bus.host_ack),   32'(e.ack));
         chk("host_err",   32'(bus.host_err),   32'(e.err));
         chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
         chk("clear_busy", 32'(bus.clear_busy), 32'(e.busy));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
      chk({tag, "_mem_waddr"},  32'(bus.mem_waddr),  32'd0);
      chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
      chk({tag, "_host_ack"},   32'(bus.host_ack),   32'd0);
      chk({tag, "_host_err"},   32'(bus.host_err),   32'd0);
      chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
      chk({tag, "_clear_busy"}, 32'(bus.clear_busy), 32'd0);
   endtask

   task automatic idle_inputs();
      bus.cam_valid   = 1'b0;
      bus.cam_sof     = 1'b0;
      bus.cam_data    = '0;
      bus.host_req    = 1'b0;
      bus.host_addr   = '0;
      bus.host_data   = '0;
      bus.clear_start = 1'b0;
   endtask

   initial begin
      int ck;
      logic camNow;
      int camIdx;
      checks   = 0;
      errors   = 0;
      heldAddr = '0;
      heldData = '0;
      idle_inputs();

      // Reset: all outputs zero
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rstn = 1'b1;

      // One full frame of 16 pixels starting with sof
      for (int i = 0; i < 16; i++) begin
         bus.cam_valid = 1'b1;
         bus.cam_sof   = (i == 0);
         bus.cam_data  = DATA_W'(i + 1);
         push(1'b1, i, i + 1, 1'b0, 1'b0, (i == 15), 1'b0);
         cycle();
      end
      idle_inputs();
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      // 20 pixels without a second sof: wraps 15 -> 0, frame_done once
      for (int i = 0; i < 20; i++) begin
         bus.cam_valid = 1'b1;
         bus.cam_sof   = (i == 0);
         bus.cam_data  = DATA_W'(12'h100 + i);
         push(1'b1, i % 16, 12'h100 + i, 1'b0, 1'b0, (i == 15), 1'b0);
         cycle();
      end
      // Mid-frame sof with a pixel restarts at 0
      bus.cam_sof  = 1'b1;
      bus.cam_data = 12'h2AA;
      push(1'b1, 0, 12'h2AA, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.cam_sof  = 1'b0;
      bus.cam_data = 12'h2AB;
      push(1'b1, 1, 12'h2AB, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      // sof without valid: no write, next pixel lands at 0
      bus.cam_valid = 1'b0;
      bus.cam_sof   = 1'b1;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.cam_valid = 1'b1;
      bus.cam_sof   = 1'b0;
      bus.cam_data  = 12'h2AC;
      push(1'b1, 0, 12'h2AC, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      idle_inputs();

      // Host held off by 5 camera cycles, then written with ack
      bus.host_req  = 1'b1;
      bus.host_addr = ADDR_W'(7);
      bus.host_data = 12'hABC;
      for (int i = 0; i < 5; i++) begin
         bus.cam_valid = 1'b1;
         bus.cam_sof   = (i == 0);
         bus.cam_data  = DATA_W'(12'h300 + i);
         push(1'b1, i, 12'h300 + i, 1'b0, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      bus.cam_valid = 1'b0;
      bus.cam_sof   = 1'b0;
      push(1'b1, 7, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.host_req = 1'b0;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      // Host out of range (addr 16): ack+err, no write
      bus.host_req  = 1'b1;
      bus.host_addr = ADDR_W'(16);
      bus.host_data = 12'hFFF;
      push(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle();
      // Last valid host address (15) written normally
      bus.host_addr = ADDR_W'(15);
      bus.host_data = 12'h5A5;
      push(1'b1, 15, 12'h5A5, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.host_req = 1'b0;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      // Clear with three interleaved camera pixels and an ignored restart
      bus.clear_start = 1'b1;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      bus.clear_start = 1'b0;
      ck = 0;
      camIdx = 0;
      for (int c = 0; c < 19; c++) begin
         camNow          = (c == 2 || c == 7 || c == 12);
         bus.cam_valid   = camNow;
         bus.cam_sof     = (c == 2);
         bus.cam_data    = DATA_W'(12'hC00 + camIdx);
         bus.clear_start = (c == 5);
         if (camNow) begin
            push(1'b1, camIdx, 12'hC00 + camIdx, 1'b0, 1'b0, 1'b0, 1'b1);
            camIdx++;
         end else begin
            push(1'b1, ck, 12'h000, 1'b0, 1'b0, 1'b0, (ck != 15));
            ck++;
         end
         cycle();
      end
      idle_inputs();
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      // Reset during clear at counter 6
      bus.clear_start = 1'b1;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      bus.clear_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push(1'b1, k, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
         cycle();
      end
      rstn = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      heldAddr = '0;
      heldData = '0;
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      bus.cam_valid = 1'b1;
      bus.cam_data  = 12'h777;
      push(1'b1, 0, 12'h777, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      // Simultaneous sof+valid+host+clear_start: camera first, host next, then clear
      bus.cam_sof     = 1'b1;
      bus.cam_data    = 12'hD00;
      bus.host_req    = 1'b1;
      bus.host_addr   = ADDR_W'(9);
      bus.host_data   = 12'h999;
      bus.clear_start = 1'b1;
      push(1'b1, 0, 12'hD00, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      bus.cam_valid   = 1'b0;
      bus.cam_sof     = 1'b0;
      bus.clear_start = 1'b0;
      push(1'b1, 9, 12'h999, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle();
      bus.host_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         push(1'b1, k, 12'h000, 1'b0, 1'b0, 1'b0, (k != 15));
         cycle();
      end
      push(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
